// File: rtl/ps2_frame_receiver_if.sv
// Read-side port bundle of the PS/2 frame receiver: FIFO head, valid/ready handshake and fill level.
interface ps2_frame_receiver_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
);
  logic [DATA_BITS-1:0]        rd_data;
  logic                        rd_valid;
  logic                        rd_ready;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  modport master (
    output rd_data,
    output rd_valid,
    output fifo_count,
    input  rd_ready
  );

  modport slave (
    input  rd_data,
    input  rd_valid,
    input  fifo_count,
    output rd_ready
  );
endinterface

// File: rtl/ps2_frame_receiver.sv
// PS/2 device-to-host frame receiver with framing/parity/timeout detection and a small read FIFO.
// Parity checking is enabled by defining PS2_PARITY_CHECK_EN; otherwise the parity bit is ignored.
module ps2_frame_receiver #(
  parameter int DATA_BITS      = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 ps2_clk_posedge,
  input  logic                 ps2_data,
  ps2_frame_receiver_if.master rd,
  output logic                 busy,
  output logic                 err_strb,
  output logic [1:0]           err_code,
  output logic                 overflow_strb
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = PTR_W + 1;
  localparam int BCNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES) + 1;

  localparam logic [BCNT_W-1:0] BIT_LAST = BCNT_W'(DATA_BITS - 1);
  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [FCNT_W-1:0] FIFO_FULL = FCNT_W'(FIFO_DEPTH);

`ifdef PS2_PARITY_CHECK_EN
  localparam bit PARITY_CHECK = 1'b1;
`else
  localparam bit PARITY_CHECK = 1'b0;
`endif

  localparam logic [1:0] ERR_FRAMING = 2'd1;
  localparam logic [1:0] ERR_PARITY  = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t                state_reg, state_next;
  logic [DATA_BITS-1:0]  shift_reg, shift_next, shifted;
  logic [BCNT_W-1:0]     bit_cnt_reg, bit_cnt_next;
  logic                  parity_reg, parity_next;
  logic [TO_W-1:0]       to_cnt_reg, to_cnt_next;
  logic                  err_strb_reg, err_set;
  logic [1:0]            err_code_reg, err_val;
  logic                  overflow_reg, overflow_next;
  logic                  frame_good, parity_ok;

  logic [DATA_BITS-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg, rd_ptr_reg;
  logic [FCNT_W-1:0]     count_reg, count_next;
  logic                  fifo_full, push, pop;

  // Right shift: first received bit ends up at the LSB after DATA_BITS samples.
  generate
    if (DATA_BITS == 1) begin : g_shift1
      assign shifted = ps2_data;
    end else begin : g_shiftn
      assign shifted = {ps2_data, shift_reg[DATA_BITS-1:1]};
    end
  endgenerate

  assign parity_ok = ^{shift_reg, parity_reg};

  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    bit_cnt_next = bit_cnt_reg;
    parity_next  = parity_reg;
    to_cnt_next  = to_cnt_reg + 1'b1;
    err_set      = 1'b0;
    err_val      = err_code_reg;
    frame_good   = 1'b0;

    if (!enable) begin
      state_next  = IDLE;
      to_cnt_next = '0;
    end else if (ps2_clk_posedge) begin
      to_cnt_next = '0;
      case (state_reg)
        IDLE: begin
          if (!ps2_data) begin
            state_next   = DATA;
            bit_cnt_next = '0;
          end else begin
            err_set = 1'b1;
            err_val = ERR_FRAMING;
          end
        end
        DATA: begin
          shift_next   = shifted;
          bit_cnt_next = bit_cnt_reg + 1'b1;
          if (bit_cnt_reg == BIT_LAST) begin
            state_next = PARITY;
          end
        end
        PARITY: begin
          parity_next = ps2_data;
          state_next  = STOP;
        end
        STOP: begin
          state_next = IDLE;
          if (!ps2_data) begin
            err_set = 1'b1;
            err_val = ERR_FRAMING;
          end else if (PARITY_CHECK && !parity_ok) begin
            err_set = 1'b1;
            err_val = ERR_PARITY;
          end else begin
            frame_good = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end else if (state_reg == IDLE) begin
      to_cnt_next = '0;
    end else if (to_cnt_reg == TO_LAST) begin
      state_next  = IDLE;
      to_cnt_next = '0;
      err_set     = 1'b1;
      err_val     = ERR_TIMEOUT;
    end
  end

  // A full FIFO still accepts a push when the head is popped on the same edge.
  assign fifo_full     = (count_reg == FIFO_FULL);
  assign pop           = rd.rd_valid && rd.rd_ready;
  assign push          = frame_good && (!fifo_full || pop);
  assign overflow_next = frame_good && fifo_full && !pop;

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      shift_reg    <= '0;
      bit_cnt_reg  <= '0;
      parity_reg   <= 1'b0;
      to_cnt_reg   <= '0;
      err_strb_reg <= 1'b0;
      err_code_reg <= 2'd0;
      overflow_reg <= 1'b0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      bit_cnt_reg  <= bit_cnt_next;
      parity_reg   <= parity_next;
      to_cnt_reg   <= to_cnt_next;
      err_strb_reg <= err_set;
      err_code_reg <= err_val;
      overflow_reg <= overflow_next;
      count_reg    <= count_next;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= shift_reg;
    end
  end

  // Head is gated so rd_data reads 0 whenever the FIFO is empty, including right after reset.
  assign rd.rd_valid   = (count_reg != '0);
  assign rd.rd_data    = rd.rd_valid ? mem[rd_ptr_reg] : '0;
  assign rd.fifo_count = count_reg;

  assign busy          = (state_reg != IDLE);
  assign err_strb      = err_strb_reg;
  assign err_code      = err_code_reg;
  assign overflow_strb = overflow_reg;

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Directed self-checking bench for ps2_frame_receiver (DATA_BITS=8, FIFO_DEPTH=4, TIMEOUT_CYCLES=100).
module tb_ps2_frame_receiver;
  localparam int DATA_BITS      = 8;
  localparam int FIFO_DEPTH     = 4;
  localparam int TIMEOUT_CYCLES = 100;

`ifdef PS2_PARITY_CHECK_EN
  localparam logic [1:0] CODE_AFTER_PARITY = 2'd2;
`else
  localparam logic [1:0] CODE_AFTER_PARITY = 2'd0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       ps2_clk_posedge = 1'b0;
  logic       ps2_data = 1'b1;
  logic       busy, err_strb, overflow_strb;
  logic [1:0] err_code;

  int n_checks = 0;
  int n_errors = 0;
  int err_pulses = 0;
  int ovf_pulses = 0;

  ps2_frame_receiver_if #(.DATA_BITS(DATA_BITS), .FIFO_DEPTH(FIFO_DEPTH)) rd_if ();

  ps2_frame_receiver #(
    .DATA_BITS(DATA_BITS),
    .FIFO_DEPTH(FIFO_DEPTH),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .ps2_clk_posedge(ps2_clk_posedge),
    .ps2_data(ps2_data),
    .rd(rd_if.master),
    .busy(busy),
    .err_strb(err_strb),
    .err_code(err_code),
    .overflow_strb(overflow_strb)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (err_strb) err_pulses++;
    if (overflow_strb) ovf_pulses++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic strobe(input logic b, input int gap);
    ps2_data = b;
    ps2_clk_posedge = 1'b1;
    @(posedge clk); #1;
    ps2_clk_posedge = 1'b0;
    ps2_data = 1'b1;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic send_head(input logic [7:0] d, input logic par_flip);
    strobe(1'b0, 2);
    for (int i = 0; i < 8; i++) strobe(d[i], 2);
    strobe((~^d) ^ par_flip, 2);
  endtask

  task automatic send_stop(input logic b, input logic with_ready);
    ps2_data = b;
    ps2_clk_posedge = 1'b1;
    rd_if.rd_ready = with_ready;
    @(posedge clk); #1;
    ps2_clk_posedge = 1'b0;
    ps2_data = 1'b1;
    rd_if.rd_ready = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d);
    send_head(d, 1'b0);
    send_stop(1'b1, 1'b0);
    $display("frame %02h sent: fifo_count=%0d err_strb=%0b", d, rd_if.fifo_count, err_strb);
  endtask

  task automatic read_expect(input string tag, input logic [7:0] exp);
    check({tag, "_valid"}, rd_if.rd_valid, 1);
    check({tag, "_data"}, rd_if.rd_data, exp);
    $display("read %02h (expected %02h)", rd_if.rd_data, exp);
    rd_if.rd_ready = 1'b1;
    @(posedge clk); #1;
    rd_if.rd_ready = 1'b0;
  endtask

  initial begin
    int n;
    int base_err;
    logic hit;
    rd_if.rd_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_valid", rd_if.rd_valid, 0);
    check("rst_count", rd_if.fifo_count, 0);
    check("rst_data", rd_if.rd_data, 0);
    check("rst_err_strb", err_strb, 0);
    check("rst_err_code", err_code, 0);
    check("rst_ovf", overflow_strb, 0);
    rst = 1'b0;
    enable = 1'b1;
    @(posedge clk); #1;

    // Single frame 0x1C, one-cycle latency to rd_valid
    send_head(8'h1C, 1'b0);
    check("f1_valid_before_stop", rd_if.rd_valid, 0);
    send_stop(1'b1, 1'b0);
    check("f1_valid", rd_if.rd_valid, 1);
    check("f1_data", rd_if.rd_data, 8'h1C);
    check("f1_count", rd_if.fifo_count, 1);
    check("f1_busy", busy, 0);
    check("f1_no_err", err_pulses, 0);
    read_expect("f1_pop", 8'h1C);
    check("f1_count_after_pop", rd_if.fifo_count, 0);

    // Three back-to-back frames, read in order
    send_frame(8'hF0);
    send_frame(8'h1C);
    send_frame(8'h5A);
    check("b2b_count", rd_if.fifo_count, 3);
    read_expect("b2b_0", 8'hF0);
    read_expect("b2b_1", 8'h1C);
    read_expect("b2b_2", 8'h5A);
    check("b2b_empty_valid", rd_if.rd_valid, 0);
    check("b2b_empty_count", rd_if.fifo_count, 0);
    check("b2b_no_err", err_pulses, 0);

    // Bad parity on 0x1C
    send_head(8'h1C, 1'b1);
    send_stop(1'b1, 1'b0);
`ifdef PS2_PARITY_CHECK_EN
    check("par_strb", err_strb, 1);
    check("par_code", err_code, 2);
    check("par_count", rd_if.fifo_count, 0);
    check("par_pulses", err_pulses, 1);
`else
    check("par_strb", err_strb, 0);
    check("par_code", err_code, 0);
    check("par_count", rd_if.fifo_count, 1);
    read_expect("par_pop", 8'h1C);
`endif

    // Fill to depth, then overflow on the fifth frame
    for (int i = 1; i <= 4; i++) send_frame(8'(i));
    check("ovf_full_count", rd_if.fifo_count, 4);
    check("ovf_none_yet", ovf_pulses, 0);
    send_frame(8'h05);
    check("ovf_strb", overflow_strb, 1);
    check("ovf_count", rd_if.fifo_count, 4);
    check("ovf_code_kept", err_code, CODE_AFTER_PARITY);
    check("ovf_head_kept", rd_if.rd_data, 8'h01);
    @(posedge clk); #1;
    check("ovf_one_pulse", ovf_pulses, 1);

    // Push while full with a pop on the same edge
    send_head(8'h06, 1'b0);
    send_stop(1'b1, 1'b1);
    check("fullpop_count", rd_if.fifo_count, 4);
    check("fullpop_ovf", overflow_strb, 0);
    read_expect("fullpop_0", 8'h02);
    read_expect("fullpop_1", 8'h03);
    read_expect("fullpop_2", 8'h04);
    read_expect("fullpop_3", 8'h06);
    check("fullpop_empty", rd_if.rd_valid, 0);
    check("fullpop_ovf_total", ovf_pulses, 1);

    // Start bit of 1 in IDLE
    strobe(1'b1, 0);
    check("start1_strb", err_strb, 1);
    check("start1_code", err_code, 1);
    check("start1_busy", busy, 0);

    // Enable drop mid-frame aborts silently
    @(posedge clk); #1;
    base_err = err_pulses;
    strobe(1'b0, 2);
    strobe(1'b1, 2);
    check("en_busy", busy, 1);
    enable = 1'b0;
    @(posedge clk); #1;
    check("en_abort_busy", busy, 0);
    enable = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    check("en_no_err", err_pulses, base_err);

    // Timeout after start plus 3 data bits
    strobe(1'b0, 2);
    strobe(1'b0, 2);
    strobe(1'b1, 2);
    strobe(1'b0, 0);
    check("to_busy", busy, 1);
    n = 0;
    hit = 1'b0;
    while (n < 200 && !hit) begin
      @(posedge clk); #1;
      n++;
      if (err_strb) hit = 1'b1;
    end
    $display("timeout seen=%0b after %0d cycles", hit, n);
    check("to_fired", hit, 1);
    check("to_latency", (n >= TIMEOUT_CYCLES - 1 && n <= TIMEOUT_CYCLES), 1);
    check("to_code", err_code, 3);
    check("to_busy_drop", busy, 0);
    send_frame(8'h5A);
    check("to_next_data", rd_if.rd_data, 8'h5A);
    check("to_next_count", rd_if.fifo_count, 1);
    read_expect("to_pop", 8'h5A);

    // Asynchronous reset mid-DATA with two entries stored
    send_frame(8'h11);
    send_frame(8'h22);
    check("ar_count_pre", rd_if.fifo_count, 2);
    strobe(1'b0, 2);
    strobe(1'b1, 2);
    strobe(1'b0, 0);
    check("ar_busy_pre", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("ar_busy", busy, 0);
    check("ar_valid", rd_if.rd_valid, 0);
    check("ar_count", rd_if.fifo_count, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Stop bit 0 gives a framing error and no push
    base_err = err_pulses;
    send_head(8'h33, 1'b0);
    send_stop(1'b0, 1'b0);
    check("stop0_strb", err_strb, 1);
    check("stop0_code", err_code, 1);
    check("stop0_count", rd_if.fifo_count, 0);
    check("stop0_valid", rd_if.rd_valid, 0);
    @(posedge clk); #1;
    check("stop0_pulses", err_pulses, base_err + 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
